// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM state encoding, sizes and the
// round-constant table.
package aes_pkg;

  localparam int         KEY_W = 128;
  localparam logic [3:0] NR    = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Indexed directly by the round counter; slot 0 and slots past NR are never consumed.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_base;

  // Entry 0 occupies the top byte, so the bit offset counts down from the MSB.
  assign w_base = {~i_byte, 3'b000};
  assign o_byte = SBOX[w_base +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: captures a cipher key, derives one round key per
// cycle into an 11-entry store, and serves registered reads by index.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [KEY_W-1:0] key_in,
  input  logic [3:0]       round_sel,
  output logic [KEY_W-1:0] round_key,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_stateNext;
  logic [3:0]       r_cnt;
  logic [KEY_W-1:0] r_rk [0:10];
  logic [KEY_W-1:0] r_roundKey;

  logic [3:0]       w_prevIdx;
  logic [KEY_W-1:0] w_prevKey;
  logic [31:0]      w_rotWord;
  logic [31:0]      w_subWord;
  logic [31:0]      w_temp;
  logic [31:0]      w_n0, w_n1, w_n2, w_n3;

  // Guarded so the read index stays inside the store while the counter sits at 0.
  assign w_prevIdx = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
  assign w_prevKey = r_rk[w_prevIdx];
  assign w_rotWord = {w_prevKey[23:0], w_prevKey[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subWord
    aes_sbox u_sbox (
      .i_byte (w_rotWord[8*g +: 8]),
      .o_byte (w_subWord[8*g +: 8])
    );
  end

  assign w_temp = w_subWord ^ {RCON[r_cnt], 24'h000000};
  assign w_n0   = w_prevKey[127:96] ^ w_temp;
  assign w_n1   = w_prevKey[95:64]  ^ w_n0;
  assign w_n2   = w_prevKey[63:32]  ^ w_n1;
  assign w_n3   = w_prevKey[31:0]   ^ w_n2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (valid) w_stateNext = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (r_cnt == NR) w_stateNext = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!valid) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // The counter saturates at NR; it is reloaded on every fresh capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else if (r_state == IDLE && valid) begin
      r_rk[0] <= key_in;
      r_cnt   <= 4'd1;
    end else if (r_state == EXPAND) begin
      r_rk[r_cnt] <= {w_n0, w_n1, w_n2, w_n3};
      if (r_cnt != NR) r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_roundKey <= '0;
    end else begin
      r_roundKey <= (round_sel <= NR) ? r_rk[round_sel] : '0;
    end
  end

  assign round_key = r_roundKey;

endmodule
